led_pwm_arbiter: RTL
====================

# led_pwm_arbiter

Shares the single Fomu RGB LED between up to NREQ requesters. Grants the LED to the highest-priority active requester and holds ownership for a minimum time. Generates the three PWM enables that feed the red/green/blue PWM inputs of the SB_RGBA_DRV hard driver. Brightness changes ramp linearly, so ownership changes appear as fades rather than steps; the hard driver's current limiting is unchanged and stays outside this block.

## Interface
- CLK_DIV, 188: clk cycles per PWM tick; PWM frame = 256 ticks (~1 kHz at 48 MHz)
- NREQ, 4: number of requesters; index 0 = highest priority
- FADE_STEP, 4: maximum per-channel level change per frame
- MIN_HOLD, 250: minimum frames in STEADY before preemption is allowed
- clk  in  1  48 MHz system clock (global-buffered)
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  level request, one bit per requester
- color  in  NREQ*24  per-requester {R[7:0],G[7:0],B[7:0]}; slot i at [24*i+23:24*i]
- grant  out  NREQ  one-hot current owner; all-zero when none
- red_pwm, green_pwm, blue_pwm  out  1 each  PWM enables to the LED driver
- busy  out  1  high in any state other than IDLE

## Operation
- Prescaler counts 0..CLK_DIV-1; `tick` pulses on the wrap. An 8-bit `pwm_cnt` advances on each tick. `frame` is the tick on which pwm_cnt goes 255->0.
- Channel output is `pwm_cnt < level`, registered. Level 0 means always off; level 255 means on for 255/256 of the frame.
- Levels, target, grant and state update only on `frame`. This keeps the PWM glitch-free.
- Target on each frame: color[owner] when grant is non-zero; otherwise 0. The color input is resampled every frame.
- Fade: per channel, `level += sign(target-level) * min(FADE_STEP, |target-level|)`. Level never overshoots and never wraps.
- FSM states:
  - IDLE: grant = 0, levels = 0.
    - On frame with any req: grant the lowest set index, go to FADE.
  - FADE: apply the fade step each frame.
    - If the owner's req is low on a frame: re-arbitrate among the remaining reqs (grant = 0 if none); stay in FADE.
    - A higher-priority req during FADE preempts immediately on the next frame.
    - When all levels equal target: go to STEADY if grant != 0, otherwise IDLE.
  - STEADY: hold_cnt increments per frame and saturates at MIN_HOLD.
    - Owner drops req: re-arbitrate, go to FADE.
    - hold_cnt == MIN_HOLD and a higher-priority req is present: grant it, clear hold_cnt, go to FADE.
    - Owner color changes: go to FADE; grant and hold_cnt are unchanged.
- Lower-priority requesters never preempt. Equal levels are impossible to contend because priority is strict.
- When the owner drops and a new req arrives in the same frame, the new req is granted; there is no IDLE detour.

## Timing
- Reset (asynchronous): state = IDLE, grant = 0, levels = 0, all pwm outputs 0, busy = 0, prescaler, pwm_cnt and hold_cnt = 0.
  - Reset mid-fade forces all outputs low immediately.
- Request to grant: registered one clk after the first frame boundary that samples req high. Worst case is one frame plus one clk.
- PWM outputs lag the pwm_cnt compare by 1 clk.
- Fade duration: ceil(max channel delta / FADE_STEP) frames.
  - Example: 0->255 with step 4 takes 64 frames.
- busy rises with grant and falls 1 clk after the frame on which the levels reach 0 with no owner.

## Structure
- Package `led_ctrl_pkg` holds:
  - state enum {IDLE, FADE, STEADY}
  - rgb_t struct {r, g, b: 8 bits}
  - PWM_BITS = 8
- Sub-module `pwm_channel`, instantiated 3x. It contains the level register, the saturating fade step toward target on frame, and the registered compare output.
- Top level contains the prescaler, pwm_cnt, priority encoder, hold counter and FSM.

## Test plan
All scenarios use CLK_DIV=2, so one frame = 512 clk.
- Reset check: assert rst_n=0 at an arbitrary clk, including mid-fade. Expect all outputs 0 within the same cycle, grant=0, busy=0.
- Single request: req=4'b0100, color[2]=FF_00_80, FADE_STEP=255, MIN_HOLD=2.
  - Expect grant=0100 after the first frame and steady state after 1 frame.
  - Expect red high 255/256, green never high, blue high exactly 128 ticks per frame.
- Fade timing: FADE_STEP=4, color 40_00_00.
  - Expect red level 4, 8, ... 64 over 16 frames, then STEADY.
  - After req drops, expect 16 frames down to 0, then busy=0.
- Preemption:
  - req1 is active in STEADY; raise req0 before MIN_HOLD=5. Expect no grant change until hold_cnt=5, then grant=0001 and a fade to color[0].
  - Raise req3 instead. Expect it is never granted while req1 is held.
- Drop-and-request in the same frame: owner req2 falls while req3 rises in the same frame. Expect grant 0100->1000 directly and the state to stay in FADE, never IDLE.
- Level extremes: color 00_FF_00.
  - Expect green high for exactly 255 of 256 ticks.
  - Expect red and blue pwm to be 0 for the whole frame, with no single-tick glitches at frame boundaries.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the RGB LED arbiter and its PWM channels.
package led_ctrl_pkg;

    localparam int PWM_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        STEADY
    } state_t;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: brightness level that ramps toward a target once per frame,
// and a registered PWM compare against the shared frame counter.
module pwm_channel
    import led_ctrl_pkg::*;
#(
    parameter int FADE_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic [PWM_BITS-1:0] level_next,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] STEP =
        (FADE_STEP > 255) ? {PWM_BITS{1'b1}} : PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] delta;

    // The step is clamped to the remaining distance, so the level can neither overshoot nor wrap.
    always_comb begin
        level_next = level;
        delta      = '0;
        if (target > level) begin
            delta      = target - level;
            level_next = level + ((delta > STEP) ? STEP : delta);
        end else if (target < level) begin
            delta      = level - target;
            level_next = level - ((delta > STEP) ? STEP : delta);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            pwm   <= 1'b0;
        end else begin
            if (frame) level <= level_next;
            pwm <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_pwm_arbiter.sv
// Shares one RGB LED between NREQ prioritised requesters; ownership changes
// fade linearly and all updates happen on PWM frame boundaries.
module led_pwm_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 188,
    parameter int NREQ      = 4,
    parameter int FADE_STEP = 4,
    parameter int MIN_HOLD  = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*24-1:0] color,
    output logic [NREQ-1:0]   grant,
    output logic              red_pwm,
    output logic              green_pwm,
    output logic              blue_pwm,
    output logic              busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int SLOT_W = $bits(rgb_t);

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                frame;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d, pick;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic                owner_req, higher_req, all_done, color_changed;
    rgb_t                target, level, level_next;

    assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame = tick && (pwm_cnt == {PWM_BITS{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Lowest set index wins; grant_q - 1 masks exactly the higher-priority slots.
    assign pick          = req & (~req + 1'b1);
    assign owner_req     = |(req & grant_q);
    assign higher_req    = |(req & (grant_q - 1'b1));
    assign all_done      = (level_next == target);
    assign color_changed = (level != target);
    assign hold_inc      = (hold_q == HOLD_W'(MIN_HOLD)) ? hold_q : hold_q + 1'b1;

    always_comb begin
        target = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) target = rgb_t'(color[SLOT_W*i +: SLOT_W]);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        if (frame) begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_d = pick;
                        hold_d  = '0;
                        state_d = FADE;
                    end
                end
                FADE: begin
                    // Covers owner drop, higher-priority preemption and pickup after a fade-out.
                    grant_d = pick;
                    if (pick != grant_q) begin
                        hold_d = '0;
                    end else if (all_done) begin
                        state_d = (|grant_q) ? STEADY : IDLE;
                    end
                end
                STEADY: begin
                    hold_d = hold_inc;
                    if (!owner_req || (hold_q == HOLD_W'(MIN_HOLD) && higher_req)) begin
                        grant_d = pick;
                        hold_d  = '0;
                        state_d = FADE;
                    end else if (color_changed) begin
                        hold_d  = hold_q;
                        state_d = FADE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_red (
        .clk(clk), .rst_n(rst_n), .frame(frame), .target(target.r), .pwm_cnt(pwm_cnt),
        .level(level.r), .level_next(level_next.r), .pwm(red_pwm)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_green (
        .clk(clk), .rst_n(rst_n), .frame(frame), .target(target.g), .pwm_cnt(pwm_cnt),
        .level(level.g), .level_next(level_next.g), .pwm(green_pwm)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_blue (
        .clk(clk), .rst_n(rst_n), .frame(frame), .target(target.b), .pwm_cnt(pwm_cnt),
        .level(level.b), .level_next(level_next.b), .pwm(blue_pwm)
    );

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule
